multdiv_sequencer: RTL and testbench

Controls the multi-cycle multiply/divide unit that sits beside the ALU in the execute stage of the 5-stage pipeline. It decodes the instruction held in the DX latch, starts the unit with a one-cycle `ctrl_MULT`/`ctrl_DIV` pulse and holds the front of the pipeline (PC, FD, DX) with `stall` until the result arrives. When the result arrives it presents the result for exactly one cycle so that the DX→XM transfer captures it. A watchdog counter bounds the wait, and a pipeline flush cancels an operation that is in flight.

---
 rtl/multdiv_sequencer_if.sv | 39 +++
 rtl/multdiv_sequencer.sv | 126 ++++++++++++
 tb/tb_multdiv_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer_if
//   Groups the signals between the execute-stage pipeline/multdiv unit and the
//   multdiv_sequencer.
//   slave  : the sequencer side (decodes DX, drives start pulses, stall, result)
//   master : the pipeline / multdiv unit side
//   Signals:
//     dx_ir, dx_valid, flush        - DX latch contents and squash request
//     data_resultRDY/exception/result - multdiv unit completion
//     ctrl_MULT, ctrl_DIV           - one-cycle start pulses
//     stall, md_busy, md_valid      - pipeline control / status
//     md_result, md_ovf, md_dest    - registered completion values
// -----------------------------------------------------------------------------
interface multdiv_sequencer_if;
  logic [31:0] dx_ir;
  logic        dx_valid;
  logic        flush;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        md_busy;
  logic        md_valid;
  logic [31:0] md_result;
  logic        md_ovf;
  logic [4:0]  md_dest;

  modport slave (
    input  dx_ir, dx_valid, flush, data_resultRDY, data_exception, data_result,
    output ctrl_MULT, ctrl_DIV, stall, md_busy, md_valid, md_result, md_ovf, md_dest
  );

  modport master (
    output dx_ir, dx_valid, flush, data_resultRDY, data_exception, data_result,
    input  ctrl_MULT, ctrl_DIV, stall, md_busy, md_valid, md_result, md_ovf, md_dest
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//   Execute-stage controller for the multi-cycle multiply/divide unit. Decodes
//   mul/div in DX, fires a one-cycle ctrl_MULT/ctrl_DIV pulse, stalls PC/FD/DX
//   until the result arrives (or a watchdog expires), then presents the result
//   for exactly one cycle with md_valid. A flush cancels an operation in flight.
//   Ports:
//     clock  - rising-edge clock
//     reset  - asynchronous active-low reset
//     bus    - multdiv_sequencer_if.slave (see interface file for signal list)
//   Parameters:
//     TIMEOUT - max BUSY cycles before a forced timeout completion (>= 2)
//     CNT_W   - watchdog counter width, 2**CNT_W >= TIMEOUT
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic                clock,
  input  logic                reset,
  multdiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        dest_q, dest_d;

  logic is_r, is_mul, is_div, start;
  logic ctrl_mult, ctrl_div, stall, busy, valid;

  // Operand/shamt fields are consumed by the datapath, not here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.dx_ir[21:7], bus.dx_ir[1:0]};

  assign is_r   = (bus.dx_ir[31:27] == 5'b00000);
  assign is_mul = is_r & (bus.dx_ir[6:2] == 5'b00110);
  assign is_div = is_r & (bus.dx_ir[6:2] == 5'b00111);
  // Gating with reset keeps the combinational start pulse and stall at zero
  // while reset is held, even with a mul/div sitting in DX.
  assign start  = (state_q == ST_IDLE) & reset & bus.dx_valid & ~bus.flush
                  & (is_mul | is_div);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dest_q   <= dest_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    dest_d    = dest_q;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ctrl_mult = start & is_mul;
        ctrl_div  = start & is_div;
        stall     = start;
        if (start) begin
          dest_d  = bus.dx_ir[26:22];
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        // Saturate so a long wait never wraps back below the timeout value.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (bus.data_resultRDY) begin
          result_d = bus.data_result;
          ovf_d    = bus.data_exception;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          result_d = '0;
          ovf_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // The instruction leaves DX this cycle, so IDLE decodes the next one.
        valid   = ~bus.flush;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ctrl_MULT = ctrl_mult;
  assign bus.ctrl_DIV  = ctrl_div;
  assign bus.stall     = stall;
  assign bus.md_busy   = busy;
  assign bus.md_valid  = valid;
  assign bus.md_result = result_q;
  assign bus.md_ovf    = ovf_q;
  assign bus.md_dest   = dest_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;

  multdiv_sequencer_if bus ();

  multdiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [4:0]  dest;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int n_mult = 0, n_div = 0, n_stall = 0, n_busy = 0, n_valid = 0;
  int done_k;

  localparam logic [31:0] MUL_IR  = 32'h00C22018;
  localparam logic [31:0] ADDI_IR = {5'b00101, 5'd3, 5'd1, 17'd10};
  localparam logic [31:0] ADD_IR  = {5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 2'b00};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Monitor: activity counters and scoreboard pop on every md_valid.
  exp_t mon_e;
  always @(negedge clock) begin
    if (reset) begin
      if (bus.ctrl_MULT) n_mult++;
      if (bus.ctrl_DIV)  n_div++;
      if (bus.stall)     n_stall++;
      if (bus.md_busy)   n_busy++;
      if (bus.md_valid) begin
        n_valid++;
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("md_result", bus.md_result, mon_e.res);
          check("md_ovf", bus.md_ovf, mon_e.ovf);
          check("md_dest", bus.md_dest, mon_e.dest);
          $display("txn: dest=%0d result=%08h ovf=%0b", bus.md_dest, bus.md_result, bus.md_ovf);
        end
      end
    end
  end

  task automatic clr_counts();
    n_mult = 0; n_div = 0; n_stall = 0; n_busy = 0; n_valid = 0;
  endtask

  // Issue one mul/div from DX. rdy_dly: cycles after start for data_resultRDY
  // (0 = never). flush_at: cycle after start at which flush is pulsed (0 = none).
  // done_k returns the first cycle index (start = 0) where stall is low.
  task automatic run_op(input bit div, input logic [4:0] rd, input int rdy_dly,
                        input logic [31:0] res, input bit exc, input int flush_at,
                        output int dk);
    int   k;
    exp_t e;
    clr_counts();
    bus.dx_ir          = {5'b0, rd, 5'd1, 5'd2, 5'd0, (div ? 5'b00111 : 5'b00110), 2'b00};
    bus.dx_valid       = 1'b1;
    bus.data_result    = res;
    bus.data_exception = exc;
    if (flush_at == 0) begin
      e.dest = rd;
      if (rdy_dly > 0) begin
        e.res = res; e.ovf = exc;
      end else begin
        e.res = 32'd0; e.ovf = 1'b1;
      end
      sb_q.push_back(e);
    end
    k  = 0;
    dk = -1;
    while (k < 200) begin
      @(negedge clock);
      if (k == 0)
        check(div ? "start_div" : "start_mul", {bus.ctrl_MULT, bus.ctrl_DIV}, div ? 2'b01 : 2'b10);
      else if (!bus.stall) begin
        dk = k;
        break;
      end
      @(posedge clock); #1;
      k++;
      bus.data_resultRDY = (rdy_dly > 0) && (k == rdy_dly);
      bus.flush          = (flush_at > 0) && (k == flush_at);
      if (flush_at > 0 && k == flush_at + 1) bus.dx_valid = 1'b0;
    end
    if (dk < 0) check("done_bound", 64'd0, 64'd1);
    @(posedge clock); #1;
    bus.dx_valid       = 1'b0;
    bus.data_resultRDY = 1'b0;
    bus.flush          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dx_ir = MUL_IR; bus.dx_valid = 1'b1; bus.flush = 1'b0;
    bus.data_resultRDY = 1'b0; bus.data_exception = 1'b0; bus.data_result = 32'd0;

    // Reset held with a mul in DX: everything quiet.
    repeat (3) begin
      @(negedge clock);
      check("rst_outs", {bus.ctrl_MULT, bus.ctrl_DIV, bus.stall, bus.md_busy, bus.md_valid,
                         bus.md_ovf, bus.md_dest, bus.md_result}, 64'd0);
    end
    @(posedge clock); #1;
    bus.dx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;

    // mul r3,r1,r2 with result 5 cycles after start.
    run_op(1'b0, 5'd3, 5, 32'h0000002A, 1'b0, 0, done_k);
    check("mul_done_k", done_k, 6);
    check("mul_pulses", n_mult, 1);
    check("mul_stall", n_stall, 6);
    check("mul_busy", n_busy, 5);
    check("mul_valid", n_valid, 1);

    // Divide by zero.
    run_op(1'b1, 5'd7, 1, 32'h0, 1'b1, 0, done_k);
    check("dbz_pulses", n_div, 1);
    check("dbz_stall", n_stall, 2);
    check("dbz_valid", n_valid, 1);

    // Timeout: result never arrives.
    run_op(1'b0, 5'd9, 0, 32'hDEAD, 1'b0, 0, done_k);
    check("to_done_k", done_k, 41);
    check("to_busy", n_busy, 40);
    check("to_valid", n_valid, 1);

    // Flush in the 3rd BUSY cycle, then a stray result is ignored.
    run_op(1'b1, 5'd4, 0, 32'h0, 1'b0, 3, done_k);
    check("fl_done_k", done_k, 4);
    check("fl_busy", n_busy, 3);
    check("fl_stall", n_stall, 4);
    bus.data_resultRDY = 1'b1; bus.data_result = 32'h1234;
    @(negedge clock);
    check("fl_stray_rdy", {bus.md_valid, bus.md_busy, bus.stall}, 3'b000);
    @(posedge clock); #1;
    bus.data_resultRDY = 1'b0;
    check("fl_valid", n_valid, 0);

    // Flush landing on DONE suppresses md_valid.
    run_op(1'b0, 5'd5, 2, 32'h55, 1'b0, 3, done_k);
    check("fd_done_k", done_k, 3);
    check("fd_valid", n_valid, 0);

    // Back-to-back mul then div, then non-multdiv instructions.
    run_op(1'b0, 5'd10, 2, 32'hAAAA0001, 1'b0, 0, done_k);
    check("b2b_mul_valid", n_valid, 1);
    run_op(1'b1, 5'd11, 3, 32'h00000777, 1'b0, 0, done_k);
    check("b2b_div_pulses", n_div, 1);
    check("b2b_div_stall", n_stall, 4);
    check("b2b_div_valid", n_valid, 1);
    clr_counts();
    bus.dx_valid = 1'b1;
    bus.dx_ir = ADDI_IR;
    repeat (2) @(posedge clock);
    bus.dx_ir = ADD_IR;
    repeat (2) @(posedge clock);
    bus.dx_ir = MUL_IR; bus.dx_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("other_no_stall", n_stall, 0);
    check("other_no_pulse", n_mult + n_div, 0);

    // Reset in the middle of an operation.
    bus.dx_ir = MUL_IR; bus.dx_valid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("mid_busy", bus.md_busy, 1'b1);
    #2 reset = 1'b0;
    #1 check("mid_rst_outs", {bus.stall, bus.md_busy, bus.ctrl_MULT, bus.md_dest, bus.md_result},
             64'd0);
    @(posedge clock); #1;
    bus.dx_valid = 1'b0;
    reset = 1'b1;
    clr_counts();
    bus.data_resultRDY = 1'b1;
    @(posedge clock); #1;
    bus.data_resultRDY = 1'b0;
    @(posedge clock); #1;
    check("mid_no_valid", n_valid + n_busy, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
